// File: rtl/bus_timer_responder.sv
// rtl/bus_timer_responder.sv - req/gnt/rvalid slave with prescaled 64-bit timer, compare and level irq
module bus_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_4000,
    parameter logic [31:0] WIN_SIZE  = 32'h0000_0fff,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        irq_o
);

    localparam logic [2:0] SEL_CTRL    = 3'd0;
    localparam logic [2:0] SEL_PRESC   = 3'd1;
    localparam logic [2:0] SEL_MTIME_L = 3'd2;
    localparam logic [2:0] SEL_MTIME_H = 3'd3;
    localparam logic [2:0] SEL_CMP_L   = 3'd4;
    localparam logic [2:0] SEL_CMP_H   = 3'd5;
    localparam logic [2:0] SEL_STATUS  = 3'd6;

    logic [1:0]         ctrl_q,     ctrl_d;
    logic [PRESC_W-1:0] presc_q,    presc_d;
    logic [PRESC_W-1:0] pcnt_q,     pcnt_d;
    logic [63:0]        mtime_q,    mtime_d;
    logic [63:0]        mtimecmp_q, mtimecmp_d;
    logic               match_q,    match_d;
    logic               irq_q,      irq_d;
    logic               rvalid_q,   rvalid_d;
    logic [31:0]        rdata_q,    rdata_d;
    logic               err_q,      err_d;

    logic [31:0] off;
    logic        hit;
    logic        acc;
    logic        wr;
    logic        rd;
    logic [2:0]  sel;
    logic        tick;
    logic        set_match;
    logic        clr_match;
    logic [31:0] rd_val;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return r;
    endfunction

    // Address decode; an access is only taken when not held in reset.
    always_comb begin
        off = addr_i - BASE_ADDR;
        hit = (addr_i >= BASE_ADDR) && (off <= WIN_SIZE) && (addr_i[1:0] == 2'b00)
              && (off <= 32'h18);
        sel = off[4:2];
        acc = req_i & ~rst_i;
        wr  = acc & we_i & hit & (be_i != 4'b0000);
        rd  = acc & ~we_i & hit;
    end

    // Register read multiplexer on the pre-edge (registered) state.
    always_comb begin
        rd_val = 32'h0;
        case (sel)
            SEL_CTRL:    rd_val = {30'h0, ctrl_q};
            SEL_PRESC:   rd_val = 32'(presc_q);
            SEL_MTIME_L: rd_val = mtime_q[31:0];
            SEL_MTIME_H: rd_val = mtime_q[63:32];
            SEL_CMP_L:   rd_val = mtimecmp_q[31:0];
            SEL_CMP_H:   rd_val = mtimecmp_q[63:32];
            SEL_STATUS:  rd_val = {31'h0, match_q};
            default:     rd_val = 32'h0;
        endcase
    end

    // Next-state for timer, compare, status and the response pipeline.
    always_comb begin
        ctrl_d     = ctrl_q;
        presc_d    = presc_q;
        pcnt_d     = pcnt_q;
        mtimecmp_d = mtimecmp_q;
        tick       = 1'b0;
        clr_match  = 1'b0;

        if (ctrl_q[0]) begin
            if (pcnt_q == presc_q) begin
                pcnt_d = '0;
                tick   = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
        mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;

        if (wr) begin
            case (sel)
                SEL_CTRL: ctrl_d = merge({30'h0, ctrl_q}, wdata_i, be_i) & 32'h3;
                SEL_PRESC: begin
                    presc_d = PRESC_W'(merge(32'(presc_q), wdata_i, be_i));
                    pcnt_d  = '0;
                end
                // A bus write to either MTIME half suppresses this cycle's increment.
                SEL_MTIME_L: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata_i, be_i)};
                SEL_MTIME_H: mtime_d = {merge(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
                SEL_CMP_L:   mtimecmp_d = {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], wdata_i, be_i)};
                SEL_CMP_H:   mtimecmp_d = {merge(mtimecmp_q[63:32], wdata_i, be_i), mtimecmp_q[31:0]};
                SEL_STATUS:  clr_match = be_i[0] & wdata_i[0];
                default: ;
            endcase
        end

        set_match = (mtime_q >= mtimecmp_q);
        match_d   = set_match | (match_q & ~clr_match);
        irq_d     = match_q & ctrl_q[1];

        rvalid_d  = acc;
        err_d     = acc & ~hit;
        rdata_d   = rd ? rd_val : 32'h0;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q     <= 2'b00;
            presc_q    <= '0;
            pcnt_q     <= '0;
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign gnt_o    = acc;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
// tb/tb_bus_timer_responder.sv - directed self-checking bench for bus_timer_responder
module tb_bus_timer_responder;

    localparam logic [31:0] A_CTRL   = 32'h1000_4000;
    localparam logic [31:0] A_PRESC  = 32'h1000_4004;
    localparam logic [31:0] A_MT_LO  = 32'h1000_4008;
    localparam logic [31:0] A_MT_HI  = 32'h1000_400C;
    localparam logic [31:0] A_CMP_LO = 32'h1000_4010;
    localparam logic [31:0] A_CMP_HI = 32'h1000_4014;
    localparam logic [31:0] A_STATUS = 32'h1000_4018;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        irq_o;

    int n_vec = 0;
    int n_err = 0;

    bus_timer_responder dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .gnt_o   (gnt_o),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    // One request cycle: drive at negedge, capture the response #1 after the accepting edge.
    task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, output logic g, output logic rv,
                       output logic [31:0] rd, output logic e);
        @(negedge clk);
        req_i = 1'b1; we_i = we; be_i = be; addr_i = a; wdata_i = wd;
        #1 g = gnt_o;
        @(posedge clk);
        #1;
        rv = rvalid_o; rd = rdata_o; e = err_o;
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        logic g, rv, e;
        logic [31:0] rd;
        bus(1'b1, 4'hF, a, wd, g, rv, rd, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; req_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic g, rv, e;
        logic [31:0] rd;
        @(negedge clk);
        rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = A_CTRL;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_vec++;
        if (gnt_o !== 1'b0 || rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0 || irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b rvalid=%b rdata=%h err=%b irq=%b, want all 0",
                     gnt_o, rvalid_o, rdata_o, err_o, irq_o);
        end
        req_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;

        bus(1'b0, 4'h0, A_CMP_LO, 32'h0, g, rv, rd, e);
        n_vec++;
        if (g !== 1'b1 || rv !== 1'b1 || rd !== 32'hFFFF_FFFF || e !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cmp_lo: got gnt=%b rv=%b rdata=%h err=%b, want 1 1 ffffffff 0", g, rv, rd, e);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (rvalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rvalid_single_cycle: got %b want 0", rvalid_o);
        end
        bus(1'b0, 4'h0, A_CMP_HI, 32'h0, g, rv, rd, e);
        n_vec++;
        if (rv !== 1'b1 || rd !== 32'hFFFF_FFFF || e !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cmp_hi: got rv=%b rdata=%h err=%b, want 1 ffffffff 0", rv, rd, e);
        end
        bus(1'b0, 4'h0, A_CTRL, 32'h0, g, rv, rd, e);
        n_vec++;
        if (rv !== 1'b1 || rd !== 32'h0 || e !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rv=%b rdata=%h err=%b, want 1 0 0", rv, rd, e);
        end
    endtask

    task automatic test_counting();
        logic g, rv, e;
        logic [31:0] rd;
        wr(A_PRESC, 32'd3);
        wr(A_CTRL, 32'd1);
        repeat (40) @(posedge clk);
        bus(1'b0, 4'h0, A_MT_LO, 32'h0, g, rv, rd, e);
        n_vec++;
        if (rd !== 32'd10 || e !== 1'b0) begin
            n_err++;
            $display("FAIL presc_count: got mtime_lo=%0d err=%b, want 10 0", rd, e);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = A_CTRL;
        @(posedge clk);
        #1;
        n_vec++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'd1) begin
            n_err++;
            $display("FAIL b2b_first: got rvalid=%b rdata=%h, want 1 00000001", rvalid_o, rdata_o);
        end
        @(negedge clk);
        addr_i = A_PRESC;
        @(posedge clk);
        #1;
        n_vec++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'd3) begin
            n_err++;
            $display("FAIL b2b_second: got rvalid=%b rdata=%h, want 1 00000003", rvalid_o, rdata_o);
        end
        req_i = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (rvalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got rvalid=%b want 0", rvalid_o);
        end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_match_irq();
        logic g, rv, e;
        logic [31:0] rd;
        int first_k;
        do_reset();
        wr(A_CMP_HI, 32'd0);
        wr(A_CMP_LO, 32'd5);
        wr(A_PRESC, 32'd0);
        wr(A_CTRL, 32'd3);
        first_k = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (irq_o === 1'b1 && first_k < 0) first_k = k;
        end
        n_vec++;
        if (first_k != 7) begin
            n_err++;
            $display("FAIL irq_rise_cycle: got cycle %0d want 7", first_k);
        end
        wr(A_STATUS, 32'd1);
        bus(1'b0, 4'h0, A_STATUS, 32'h0, g, rv, rd, e);
        n_vec++;
        if (rd !== 32'd1 || irq_o !== 1'b1) begin
            n_err++;
            $display("FAIL match_sticky_set_wins: got status=%h irq=%b, want 00000001 1", rd, irq_o);
        end
        wr(A_CMP_LO, 32'd1000);
        wr(A_STATUS, 32'd1);
        @(posedge clk);
        #1;
        n_vec++;
        if (irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL irq_fall: got irq=%b want 0", irq_o);
        end
        bus(1'b0, 4'h0, A_STATUS, 32'h0, g, rv, rd, e);
        n_vec++;
        if (rd !== 32'd0) begin
            n_err++;
            $display("FAIL status_cleared: got %h want 00000000", rd);
        end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_errors();
        logic g, rv, e;
        logic [31:0] rd;
        logic [31:0] bad_rd [3];
        bad_rd[0] = 32'h1000_5000;
        bad_rd[1] = 32'h1000_4002;
        bad_rd[2] = 32'h1000_401C;
        for (int i = 0; i < 3; i++) begin
            bus(1'b0, 4'h0, bad_rd[i], 32'h0, g, rv, rd, e);
            n_vec++;
            if (rv !== 1'b1 || e !== 1'b1 || rd !== 32'h0) begin
                n_err++;
                $display("FAIL err_read_%h: got rv=%b err=%b rdata=%h, want 1 1 0", bad_rd[i], rv, e, rd);
            end
        end
        bus(1'b1, 4'hF, 32'h1000_4001, 32'h3, g, rv, rd, e);
        n_vec++;
        if (e !== 1'b1) begin
            n_err++;
            $display("FAIL err_write_misaligned: got err=%b want 1", e);
        end
        bus(1'b1, 4'hF, 32'h1000_3FFC, 32'h3, g, rv, rd, e);
        n_vec++;
        if (e !== 1'b1) begin
            n_err++;
            $display("FAIL err_write_below_base: got err=%b want 1", e);
        end
        bus(1'b1, 4'h0, A_CTRL, 32'h3, g, rv, rd, e);
        n_vec++;
        if (rv !== 1'b1 || e !== 1'b0 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL be0_write: got rv=%b err=%b rdata=%h, want 1 0 0", rv, e, rd);
        end
        bus(1'b0, 4'h0, A_CTRL, 32'h0, g, rv, rd, e);
        n_vec++;
        if (rd !== 32'h0 || e !== 1'b0) begin
            n_err++;
            $display("FAIL ctrl_unchanged: got ctrl=%h err=%b, want 0 0", rd, e);
        end
    endtask

    task automatic test_wrap_and_bytes();
        logic g, rv, e;
        logic [31:0] rd, rd_hi;
        do_reset();
        wr(A_PRESC, 32'd0);
        wr(A_MT_LO, 32'hFFFF_FFFF);
        wr(A_MT_HI, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'd1);
        wr(A_CTRL, 32'd0);
        bus(1'b0, 4'h0, A_MT_LO, 32'h0, g, rv, rd, e);
        bus(1'b0, 4'h0, A_MT_HI, 32'h0, g, rv, rd_hi, e);
        n_vec++;
        if (rd !== 32'h0 || rd_hi !== 32'h0) begin
            n_err++;
            $display("FAIL mtime_wrap: got %h_%h want 00000000_00000000", rd_hi, rd);
        end
        wr(A_MT_LO, 32'h0000_0100);
        wr(A_MT_HI, 32'h0);
        wr(A_CTRL, 32'd1);
        bus(1'b1, 4'b0001, A_MT_LO, 32'h5555_55AA, g, rv, rd, e);
        wr(A_CTRL, 32'd0);
        bus(1'b0, 4'h0, A_MT_LO, 32'h0, g, rv, rd, e);
        bus(1'b0, 4'h0, A_MT_HI, 32'h0, g, rv, rd_hi, e);
        n_vec++;
        if (rd !== 32'h0000_01AB || rd_hi !== 32'h0) begin
            n_err++;
            $display("FAIL byte_write_during_count: got %h_%h want 00000000_000001ab", rd_hi, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic g, rv, e;
        logic [31:0] rd, rd2, rd3, rd4;
        wr(A_PRESC, 32'd0);
        wr(A_CMP_HI, 32'd0);
        wr(A_CMP_LO, 32'd0);
        wr(A_CTRL, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (irq_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_irq: got %b want 1", irq_o);
        end
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = A_CTRL; rst_i = 1'b1;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        n_vec++;
        if (rvalid_o !== 1'b0 || irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_drops_response: got rvalid=%b irq=%b, want 0 0", rvalid_o, irq_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        bus(1'b0, 4'h0, A_CTRL, 32'h0, g, rv, rd, e);
        bus(1'b0, 4'h0, A_MT_LO, 32'h0, g, rv, rd2, e);
        bus(1'b0, 4'h0, A_STATUS, 32'h0, g, rv, rd3, e);
        bus(1'b0, 4'h0, A_CMP_LO, 32'h0, g, rv, rd4, e);
        n_vec++;
        if (rd !== 32'h0 || rd2 !== 32'h0 || rd3 !== 32'h0 || rd4 !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL post_reset_regs: got ctrl=%h mtime_lo=%h status=%h cmp_lo=%h, want 0 0 0 ffffffff",
                     rd, rd2, rd3, rd4);
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_back_to_back();
        test_match_irq();
        test_errors();
        test_wrap_and_bytes();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
